// File: rtl/tristate_mux8_scanner.sv
// tristate_mux8_scanner: scans an 8:1 tri-state mux and assembles its samples into a handshaked parallel frame.
module tristate_mux8_scanner #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic       ack,
  input  logic       clr_ovr,
  output logic       sel_i,
  output logic       sel_j,
  output logic       sel_m,
  output logic [2:0] slot,
  output logic [7:0] q,
  output logic       frame_valid,
  output logic       overrun
);
  logic [3:0] cnt;
  logic [6:0] shadow;
  logic [2:0] nxt;
  logic       samp;
  logic       done;
  logic       take;
  assign nxt  = slot + 3'd1;
  assign samp = en && cnt == 4'(SETTLE);
  assign done = samp && slot == 3'd7;
  assign take = !frame_valid || ack;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                   <= '0;
      slot                  <= '0;
      shadow                <= '0;
      {sel_m, sel_i, sel_j} <= 3'b111;
    end else if (en) begin
      cnt <= samp ? 4'd0 : cnt + 4'd1;
      if (samp) begin
        if (slot != 3'd7) shadow[slot] <= din;
        slot                  <= nxt;
        {sel_m, sel_i, sel_j} <= ~nxt;
      end
    end
  end
  // A frame completing while the previous one is still unacknowledged is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (done && take) begin
        q           <= {din, shadow};
        frame_valid <= 1'b1;
      end else if (frame_valid && ack) begin
        frame_valid <= 1'b0;
      end
      if (done && !take) overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end
endmodule

// File: doc/tristate_mux8_scanner.md
# tristate_mux8_scanner

Receive-side companion to the 8:1 tri-state mux tree. It drives the mux select lines (i, j, m) through all eight sources in a fixed scan order and samples the single shared mux output after a settling delay. It then assembles the eight samples into a parallel frame and hands that frame to downstream logic over a valid/ack handshake with overrun detection. It turns the mux into a time-division serial link from eight inputs to one parallel word.

## Interface
- SETTLE, 2: extra enabled cycles a select value is held before the shared line is sampled.
  - Legal range 0..15.
  - One slot lasts SETTLE+1 enabled cycles.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable.
  - Low freezes all scan state: slot, settle count, shadow and selects.
  - Handshake and overrun logic still operate while en is low.
- din  input  1  shared mux output (the mux Y line).
- ack  input  1  consumer accepts the current frame; meaningful only while frame_valid=1.
- clr_ovr  input  1  synchronous clear of overrun.
- sel_i  output  1  drives mux select i, registered.
- sel_j  output  1  drives mux select j, registered.
- sel_m  output  1  drives mux select m, registered.
- slot  output  3  current slot index s, registered.
- q  output  8  last delivered frame.
  - q[0]=a, q[1]=b, … q[7]=h.
- frame_valid  output  1  q holds an unacknowledged frame.
- overrun  output  1  sticky flag: a completed frame was dropped.

## Operation
- Select mapping: sel_m = ~s[2], sel_i = ~s[1], sel_j = ~s[0]. This routes source s onto din:
  - s=0 gives (m,j,i)=111 → a; s=1 gives 101 → b; s=2 gives 110 → c; s=3 gives 100 → d.
  - s=4 gives 011 → e; s=5 gives 001 → f; s=6 gives 010 → g; s=7 gives 000 → h.
- Internal state: settle counter cnt (0..SETTLE) and 7-bit shadow register.
- On an edge with en=1:
  - If cnt<SETTLE: cnt increments.
  - If cnt==SETTLE: sample din into bit s, set cnt to 0, advance s to s+1 mod 8, and update the selects from the new s at the same edge.
- Slot 7 sample (frame completion edge): the candidate frame is {din, shadow[6:0]}.
  - If frame_valid=0, or frame_valid=1 with ack=1: q loads the candidate and frame_valid is 1 after the edge.
  - If frame_valid=1 with ack=0: the candidate is discarded, q holds, and overrun is set.
- No completion, frame_valid=1, ack=1: frame_valid clears to 0.
- ack with frame_valid=0 is ignored.
- Overrun:
  - Cleared by clr_ovr=1.
  - If set and clear occur on the same edge, set wins.
- Scan wrap 7→0 is seamless; there is no idle slot between frames.
- Reset values:
  - slot=0, selects (m,j,i)=111, cnt=0, shadow=0.
  - q=0, frame_valid=0, overrun=0.
- Reset asserted mid-frame discards the partial frame. Scanning restarts at slot 0 after release.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Selects change on the same edge that takes the previous slot's sample. The new source therefore has SETTLE full cycles, plus the remainder of the sampling cycle, to settle before its own sample.
- Frame period: 8·(SETTLE+1) enabled cycles.
- First frame_valid rises on the 8·(SETTLE+1)-th enabled edge after reset release. With SETTLE=2 that is the 24th edge.
- Handshake: frame_valid stays high until the edge where ack=1 is sampled. Data in q is stable while frame_valid=1.
- en low for N cycles stretches the current slot by exactly N cycles; samples are never taken while en=0.

## Test plan
- Source pattern a..h = 1,0,1,1,0,0,1,0 through a mux model, SETTLE=2, ack tied 1 → q=8'b01001101 on edge 24, then again every 24 edges; overrun stays 0.
- Slot sweep → after each sample edge, (sel_m,sel_j,sel_i) follows 111,101,110,100,011,001,010,000, then wraps to 111.
- ack held 0 across two frame periods → first frame is held in q and frame_valid=1; on edge 48 overrun=1 and q is unchanged. clr_ovr pulse → overrun=0.
- ack=1 on the same edge as a frame completion → q takes the new frame and frame_valid stays 1 with no gap.
- en dropped for 5 cycles mid-slot 3 → frame completes on edge 29 (24+5) with correct data; selects are frozen during the gap.
- rst asserted asynchronously mid-slot 5 → outputs go to slot=0, selects 111, q=0, frame_valid=0, overrun=0 immediately. First frame completes 24 enabled edges after release.
